// File: rtl/ram_dp_fifo_ctrl_if.sv
// RAM-side bus between the FIFO controller and the dual-port registered-read RAM.
// The controller owns the master modport and the RAM owns the slave modport.
interface ram_dp_fifo_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16
);
   localparam int ADDR_WIDTH = $clog2(DEPTH);

   logic                      ram_cen;
   logic                      ram_wen_a;
   logic [ADDR_WIDTH-1:0]     ram_addr_a;
   logic [DATA_WIDTH-1:0]     ram_din_a;
   logic                      ram_wen_b;
   logic [DATA_WIDTH/8-1:0]   ram_bwen_b;
   logic [ADDR_WIDTH-1:0]     ram_addr_b;
   logic [DATA_WIDTH-1:0]     ram_dout_b;

   modport master (
      output ram_cen, ram_wen_a, ram_addr_a, ram_din_a,
      output ram_wen_b, ram_bwen_b, ram_addr_b,
      input  ram_dout_b
   );

   modport slave (
      input  ram_cen, ram_wen_a, ram_addr_a, ram_din_a,
      input  ram_wen_b, ram_bwen_b, ram_addr_b,
      output ram_dout_b
   );
endinterface

// File: rtl/ram_dp_fifo_ctrl.sv
// First-word-fall-through valid/ready FIFO controller in front of a dual-port RAM
// whose port-B read data is registered; port A writes, port B always reads.
module ram_dp_fifo_ctrl #(
   parameter  int DATA_WIDTH  = 32,
   parameter  int DEPTH       = 16,
   parameter  int AFULL_LEVEL = DEPTH - 2,
   localparam int ADDR_WIDTH  = $clog2(DEPTH),
   localparam int CNT_WIDTH   = $clog2(DEPTH + 1)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   input  logic [DATA_WIDTH-1:0]  in_data,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [DATA_WIDTH-1:0]  out_data,
   input  logic                   out_ready,
   output logic [CNT_WIDTH-1:0]   count,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   ram_dp_fifo_ctrl_if.master     ram
);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH-1:0] wr_ptr_next;
   logic [ADDR_WIDTH-1:0] rd_ptr_next;
   logic [CNT_WIDTH-1:0]  count_next;
   logic                  wr_d1;
   logic [ADDR_WIDTH-1:0] wr_addr_d1;
   logic                  push;
   logic                  pop;
   logic                  head_hazard;

   // Explicit wrap compare so non-power-of-two depths address only DEPTH entries.
   function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
      return (p == ADDR_WIDTH'(DEPTH - 1)) ? '0 : p + ADDR_WIDTH'(1);
   endfunction

   assign full        = (count == CNT_WIDTH'(DEPTH));
   assign empty       = (count == '0);
   assign almost_full = (count >= CNT_WIDTH'(AFULL_LEVEL));
   assign in_ready    = !full;

   // The head entry written on the previous edge is not yet visible on port B.
   assign head_hazard = wr_d1 && (wr_addr_d1 == rd_ptr);
   assign out_valid   = !empty && !head_hazard;
   assign out_data    = ram.ram_dout_b;

   assign push = in_valid && in_ready && !flush;
   assign pop  = out_valid && out_ready && !flush;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      wr_ptr_next = wr_ptr;
      rd_ptr_next = rd_ptr;
      count_next  = count;
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (push) wr_ptr_next = ptr_inc(wr_ptr);
         if (pop)  rd_ptr_next = ptr_inc(rd_ptr);
         if (push && !pop)      count_next = count + CNT_WIDTH'(1);
         else if (pop && !push) count_next = count - CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         wr_d1      <= 1'b0;
         wr_addr_d1 <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         wr_ptr     <= wr_ptr_next;
         rd_ptr     <= rd_ptr_next;
         count      <= count_next;
         wr_d1      <= push;
         wr_addr_d1 <= wr_ptr;
      end
   end

   // Port B reads the next head address so its registered output tracks rd_ptr.
   assign ram.ram_cen    = 1'b1;
   assign ram.ram_wen_a  = push;
   assign ram.ram_addr_a = wr_ptr;
   assign ram.ram_din_a  = in_data;
   assign ram.ram_wen_b  = 1'b0;
   assign ram.ram_bwen_b = '1;
   assign ram.ram_addr_b = rd_ptr_next;

endmodule

// File: tb/tb_ram_dp_fifo_ctrl.sv
// Directed bench for ram_dp_fifo_ctrl with a behavioural registered-read RAM
// attached to the controller's RAM bus.
module tb_ram_dp_fifo_ctrl;
   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int CW    = 5;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          out_ready = 1'b0;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          almost_full;

   int checks = 0;
   int errors = 0;

   ram_dp_fifo_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) ram_bus ();

   ram_dp_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .ram         (ram_bus)
   );

   always #5 clock = ~clock;

   // Registered-read RAM: read-before-write on a same-address collision.
   logic [DW-1:0] mem [DEPTH];
   initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;

   always @(posedge clock)
      if (ram_bus.ram_cen && ram_bus.ram_wen_a) mem[ram_bus.ram_addr_a] <= ram_bus.ram_din_a;

   always @(posedge clock or posedge reset)
      if (reset) ram_bus.ram_dout_b <= '0;
      else if (ram_bus.ram_cen) ram_bus.ram_dout_b <= mem[ram_bus.ram_addr_b];

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic do_reset;
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
      @(negedge clock);
      reset = 1'b1;
      #2;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      #2;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", full); end
      checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rst_afull got %b exp 0", almost_full); end
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
      checks++; if (ram_bus.ram_wen_a !== 1'b0) begin errors++; $display("FAIL rst_wen_a got %b exp 0", ram_bus.ram_wen_a); end
      checks++; if (ram_bus.ram_addr_a !== 4'd0) begin errors++; $display("FAIL rst_addr_a got %0d exp 0", ram_bus.ram_addr_a); end
      checks++; if (ram_bus.ram_addr_b !== 4'd0) begin errors++; $display("FAIL rst_addr_b got %0d exp 0", ram_bus.ram_addr_b); end
      checks++; if (ram_bus.ram_cen !== 1'b1) begin errors++; $display("FAIL rst_cen got %b exp 1", ram_bus.ram_cen); end
      checks++; if (ram_bus.ram_wen_b !== 1'b0) begin errors++; $display("FAIL rst_wen_b got %b exp 0", ram_bus.ram_wen_b); end
      checks++; if (ram_bus.ram_bwen_b !== 4'hF) begin errors++; $display("FAIL rst_bwen_b got %h exp f", ram_bus.ram_bwen_b); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_push;
      do_reset();
      in_valid = 1'b1; in_data = 32'hA5A5_A5A5;
      settle();
      checks++; if (ram_bus.ram_wen_a !== 1'b1) begin errors++; $display("FAIL single_wen got %b exp 1", ram_bus.ram_wen_a); end
      checks++; if (ram_bus.ram_din_a !== 32'hA5A5_A5A5) begin errors++; $display("FAIL single_din got %h exp a5a5a5a5", ram_bus.ram_din_a); end
      tick();
      in_valid = 1'b0;
      settle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_c1_valid got %b exp 0", out_valid); end
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_c1_count got %0d exp 1", count); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_c1_empty got %b exp 0", empty); end
      tick();
      settle();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_c2_valid got %b exp 1", out_valid); end
      checks++; if (out_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL single_c2_data got %h exp a5a5a5a5", out_data); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      settle();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty got %b exp 1", empty); end
   endtask

   task automatic test_fill;
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         in_valid = 1'b1; in_data = DW'(i);
         settle();
         checks++; if (count !== CW'(i)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i); end
         checks++; if (almost_full !== (i >= 14)) begin errors++; $display("FAIL fill_afull[%0d] got %b exp %b", i, almost_full, (i >= 14)); end
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready[%0d] got %b exp 1", i, in_ready); end
         checks++; if (ram_bus.ram_addr_a !== AW'(i)) begin errors++; $display("FAIL fill_addr_a[%0d] got %0d exp %0d", i, ram_bus.ram_addr_a, i); end
         tick();
      end
      in_valid = 1'b1; in_data = 32'd16;
      settle();
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %b exp 0", in_ready); end
      checks++; if (ram_bus.ram_wen_a !== 1'b0) begin errors++; $display("FAIL fill_17th_wen got %b exp 0", ram_bus.ram_wen_a); end
      checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count16 got %0d exp 16", count); end
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         out_ready = 1'b1;
         settle();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got %b exp 1", i, out_valid); end
         checks++; if (out_data !== DW'(i)) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, out_data, DW'(i)); end
         tick();
      end
      out_ready = 1'b0;
      settle();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid got %b exp 0", out_valid); end
   endtask

   task automatic test_back_to_back;
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         in_valid = 1'b1; in_data = DW'(100 + k);
         settle();
         checks++; if (ram_bus.ram_addr_a !== AW'(k % 16)) begin errors++; $display("FAIL b2b_addr_a[%0d] got %0d exp %0d", k, ram_bus.ram_addr_a, k % 16); end
         checks++; if (out_valid !== (k >= 2)) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp %b", k, out_valid, (k >= 2)); end
         if (k >= 2) begin
            checks++; if (out_data !== DW'(100 + k - 2)) begin errors++; $display("FAIL b2b_data[%0d] got %0d exp %0d", k, out_data, 100 + k - 2); end
         end
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b0;
      settle();
      checks++; if (count !== 5'd2) begin errors++; $display("FAIL b2b_final_count got %0d exp 2", count); end
   endtask

   task automatic test_push_pop_same;
      do_reset();
      in_valid = 1'b1; in_data = 32'h1111_0001;
      tick();
      in_valid = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         settle();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %b exp 1", i, out_valid); end
         checks++; if (out_data !== 32'h1111_0001) begin errors++; $display("FAIL hold_data[%0d] got %h exp 11110001", i, out_data); end
         tick();
      end
      in_valid = 1'b1; in_data = 32'h2222_0002; out_ready = 1'b1;
      settle();
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL pp_count_before got %0d exp 1", count); end
      checks++; if (out_data !== 32'h1111_0001) begin errors++; $display("FAIL pp_head got %h exp 11110001", out_data); end
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      settle();
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL pp_count_after got %0d exp 1", count); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pp_hazard_valid got %b exp 0", out_valid); end
      tick();
      settle();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pp_new_valid got %b exp 1", out_valid); end
      checks++; if (out_data !== 32'h2222_0002) begin errors++; $display("FAIL pp_new_data got %h exp 22220002", out_data); end
   endtask

   task automatic test_flush;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = DW'(32'h50 + i);
         tick();
      end
      in_valid = 1'b0;
      tick();
      settle();
      checks++; if (count !== 5'd5) begin errors++; $display("FAIL flush_pre_count got %0d exp 5", count); end
      flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
      settle();
      checks++; if (ram_bus.ram_wen_a !== 1'b0) begin errors++; $display("FAIL flush_wen got %b exp 0", ram_bus.ram_wen_a); end
      checks++; if (ram_bus.ram_addr_b !== 4'd0) begin errors++; $display("FAIL flush_addr_b got %0d exp 0", ram_bus.ram_addr_b); end
      tick();
      flush = 1'b0; in_valid = 1'b0;
      settle();
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b exp 1", empty); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
      checks++; if (mem[5] === 32'hDEAD_BEEF) begin errors++; $display("FAIL flush_mem5 got %h exp not deadbeef", mem[5]); end
      in_valid = 1'b1; in_data = 32'h77;
      settle();
      checks++; if (ram_bus.ram_addr_a !== 4'd0) begin errors++; $display("FAIL flush_next_addr got %0d exp 0", ram_bus.ram_addr_a); end
      tick();
      in_valid = 1'b0;
      settle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_c1_valid got %b exp 0", out_valid); end
      tick();
      settle();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_c2_valid got %b exp 1", out_valid); end
      checks++; if (out_data !== 32'h77) begin errors++; $display("FAIL flush_c2_data got %h exp 77", out_data); end
   endtask

   task automatic test_reset_midstream;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1; in_data = DW'(32'h70 + i);
         tick();
      end
      in_valid = 1'b0;
      tick();
      settle();
      checks++; if (count !== 5'd7) begin errors++; $display("FAIL mid_pre_count got %0d exp 7", count); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %b exp 1", empty); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b exp 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", out_valid); end
      checks++; if (ram_bus.ram_addr_a !== 4'd0) begin errors++; $display("FAIL mid_addr_a got %0d exp 0", ram_bus.ram_addr_a); end
      checks++; if (ram_bus.ram_addr_b !== 4'd0) begin errors++; $display("FAIL mid_addr_b got %0d exp 0", ram_bus.ram_addr_b); end
      #2;
      reset = 1'b0;
      tick();
      in_valid = 1'b1; in_data = 32'h1234;
      settle();
      checks++; if (ram_bus.ram_addr_a !== 4'd0) begin errors++; $display("FAIL mid_new_addr got %0d exp 0", ram_bus.ram_addr_a); end
      tick();
      in_valid = 1'b0;
      tick();
      settle();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_new_valid got %b exp 1", out_valid); end
      checks++; if (out_data !== 32'h1234) begin errors++; $display("FAIL mid_new_data got %h exp 1234", out_data); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_push();
      test_fill();
      test_back_to_back();
      test_push_pop_same();
      test_flush();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
